dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared byte-addressed data memory.
- Master 0 is the core load/store path; master 1 is a debug/DMA loader.
- Handles valid/ready request handshakes, round-robin grant, alignment and range checking, and single-cycle strobe generation.
- Aligns responses with the memory's registered read, which is valid one cycle after the strobe.

---
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter and sequencer for the shared
// byte-addressed data memory. Checks alignment and range, raises a one-cycle
// read or write strobe, and returns the memory's registered read data one
// cycle after the strobe.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_we,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_we,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic        lat_we;
    logic        lat_err;

    logic        grant;
    logic        accept;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        rd_ok;

    // Round-robin grant and selection of the granted master's request
    always_comb begin
        grant        = 1'b0;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        if (m0_req_valid && m1_req_valid) begin
            grant = ~last_grant;
        end else if (m1_req_valid) begin
            grant = 1'b1;
        end
        if (state == IDLE) begin
            m0_req_ready = m0_req_valid && !grant;
            m1_req_ready = m1_req_valid && grant;
        end
        accept    = m0_req_ready || m1_req_ready;
        sel_we    = grant ? m1_req_we    : m0_req_we;
        sel_addr  = grant ? m1_req_addr  : m0_req_addr;
        sel_wdata = grant ? m1_req_wdata : m0_req_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
    end

    // Sequencer: accept, issue a one-cycle strobe, then deliver the response.
    // mem_addr/mem_wdata double as the latched address and write data; they
    // load only on a good accept so they hold their value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            lat_we       <= 1'b0;
            lat_err      <= 1'b0;
            mem_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m0_rsp_err   <= 1'b0;
            m1_rsp_err   <= 1'b0;
        end else begin
            mem_write    <= 1'b0;
            mem_read     <= 1'b0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m0_rsp_err   <= 1'b0;
            m1_rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant;
                        last_grant <= grant;
                        lat_we     <= sel_we;
                        lat_err    <= sel_err;
                        if (sel_err) begin
                            state        <= RESP;
                            m0_rsp_valid <= !grant;
                            m1_rsp_valid <= grant;
                            m0_rsp_err   <= !grant;
                            m1_rsp_err   <= grant;
                        end else begin
                            state     <= ISSUE;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_write <= sel_we;
                            mem_read  <= !sel_we;
                        end
                    end
                end
                ISSUE: begin
                    state        <= RESP;
                    m0_rsp_valid <= !owner;
                    m1_rsp_valid <= owner;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data passes straight from the memory's registered output during RESP
    always_comb begin
        rd_ok        = !lat_we && !lat_err;
        m0_rsp_rdata = (m0_rsp_valid && rd_ok) ? mem_rdata : '0;
        m1_rsp_rdata = (m1_rsp_valid && rd_ok) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of single transactions plus
// hand-written contention and reset-during-write sequences.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic        m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic        m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    logic        mem_load;
    logic [7:0]  mem_bytes [0:255];

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.MEM_BYTES(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_we    (m0_req_we),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m0_rsp_err   (m0_rsp_err),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_we    (m1_req_we),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_rdata (m1_rsp_rdata),
        .m1_rsp_err   (m1_rsp_err),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte memory with registered read; preloaded while mem_load
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem_bytes[i] <= 8'h00;
            mem_bytes[8'h10] <= 8'h44; mem_bytes[8'h11] <= 8'h33;
            mem_bytes[8'h12] <= 8'h22; mem_bytes[8'h13] <= 8'h11;
            mem_bytes[8'h40] <= 8'h78; mem_bytes[8'h41] <= 8'h56;
            mem_bytes[8'h42] <= 8'h34; mem_bytes[8'h43] <= 8'h12;
            mem_bytes[8'hFC] <= 8'hA1; mem_bytes[8'hFD] <= 8'hB2;
            mem_bytes[8'hFE] <= 8'hC3; mem_bytes[8'hFF] <= 8'hD4;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_write) begin
                mem_bytes[mem_addr[7:0]]         <= mem_wdata[7:0];
                mem_bytes[mem_addr[7:0] + 8'd1]  <= mem_wdata[15:8];
                mem_bytes[mem_addr[7:0] + 8'd2]  <= mem_wdata[23:16];
                mem_bytes[mem_addr[7:0] + 8'd3]  <= mem_wdata[31:24];
            end
            if (mem_read) begin
                mem_rdata <= {mem_bytes[mem_addr[7:0] + 8'd3], mem_bytes[mem_addr[7:0] + 8'd2],
                              mem_bytes[mem_addr[7:0] + 8'd1], mem_bytes[mem_addr[7:0]]};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit m, input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (m) begin
            m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d;
        end else begin
            m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d;
        end
    endtask

    // One transaction by master m, started at a falling edge; ends at a falling edge in IDLE
    task automatic do_txn(input int idx, input bit m, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rd);
        bit got;
        string t;
        t = $sformatf("v%0d", idx);
        drive(m, 1'b1, we, addr, wdata);
        #1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m ? m1_req_ready : m0_req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        chk({t, " grant"}, 32'(got), 32'd1);
        if (!got) begin
            drive(m, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            return;
        end
        chk({t, " other_ready"}, 32'(m ? m0_req_ready : m1_req_ready), 32'd0);
        @(posedge clk); #1;
        drive(m, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        if (exp_err) begin
            chk({t, " err_no_rd"}, 32'(mem_read), 32'd0);
            chk({t, " err_no_wr"}, 32'(mem_write), 32'd0);
        end else begin
            chk({t, " mem_read"}, 32'(mem_read), 32'(!we));
            chk({t, " mem_write"}, 32'(mem_write), 32'(we));
            chk({t, " mem_addr"}, mem_addr, addr);
            if (we) chk({t, " mem_wdata"}, mem_wdata, wdata);
            chk({t, " early_rsp"}, 32'(m0_rsp_valid | m1_rsp_valid), 32'd0);
            @(negedge clk);
            chk({t, " strobe_off"}, 32'(mem_read | mem_write), 32'd0);
        end
        chk({t, " rsp_valid"}, 32'(m ? m1_rsp_valid : m0_rsp_valid), 32'd1);
        chk({t, " other_rsp"}, 32'(m ? m0_rsp_valid : m1_rsp_valid), 32'd0);
        chk({t, " rsp_err"}, 32'(m ? m1_rsp_err : m0_rsp_err), 32'(exp_err));
        chk({t, " rsp_rdata"}, m ? m1_rsp_rdata : m0_rsp_rdata, exp_rd);
        @(negedge clk);
        chk({t, " rsp_done"}, 32'(m0_rsp_valid | m1_rsp_valid), 32'd0);
    endtask

    typedef struct {
        bit          m;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [0:10];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'h1122_3344};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,          1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0021, 32'h0,          1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_00FD, 32'h0,          1'b1, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,          1'b0, 32'hD4C3_B2A1};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0022, 32'h5555_AAAA,  1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          1'b0, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'h1122_3344};

        rst_n = 1'b0;
        mem_load = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);

        chk("rst m0_ready", 32'(m0_req_ready), 32'd0);
        chk("rst m1_ready", 32'(m1_req_ready), 32'd0);
        chk("rst strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst rsp", 32'({m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err}), 32'd0);
        chk("rst rdata", m0_rsp_rdata | m1_rsp_rdata, 32'h0);

        mem_load = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_txn(i, vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rd);
        end

        // Contention from a fresh reset: grants alternate m0,m1,m0,m1 every 3 cycles
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, '0);
        drive(1'b1, 1'b1, 1'b0, 32'hFC, '0);
        #1;
        for (int c = 0; c < 12; c++) begin
            bit g0, g1;
            g0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
            g1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
            chk($sformatf("cont c%0d m0_ready", c), 32'(m0_req_ready), 32'(g0));
            chk($sformatf("cont c%0d m1_ready", c), 32'(m1_req_ready), 32'(g1));
            if (c % 3 == 2) begin
                chk($sformatf("cont c%0d m0_rsp", c), 32'(m0_rsp_valid), 32'(((c / 3) % 2) == 0));
                chk($sformatf("cont c%0d m1_rsp", c), 32'(m1_rsp_valid), 32'(((c / 3) % 2) == 1));
                chk($sformatf("cont c%0d rdata", c), m0_rsp_rdata | m1_rsp_rdata,
                    (((c / 3) % 2) == 0) ? 32'h1122_3344 : 32'hD4C3_B2A1);
            end
            @(negedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Reset during the ISSUE cycle of a write: no write, no response
        drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
        #1;
        chk("rstw grant", 32'(m0_req_ready), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk("rstw issue", 32'(mem_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw wr_drop", 32'(mem_write), 32'd0);
        chk("rstw rd_drop", 32'(mem_read), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rstw c%0d no_rsp", c), 32'(m0_rsp_valid | m1_rsp_valid), 32'd0);
            @(negedge clk);
        end
        do_txn(20, 1'b0, 1'b0, 32'h40, '0, 1'b0, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
